// File: rtl/n1_dsp_arb.sv
// Arbiter/sequencer that shares one DSP cell (add/sub + 16x16 mul) between the ALU and AGU.
// Optional round-robin arbitration is enabled by defining N1_DSP_ARB_ROUNDROBIN_EN.
module n1_dsp_arb #(
    parameter int unsigned DSP_LAT = 1
) (
    input  logic        clk_i,
    input  logic        async_rst_i,
    input  logic        alu2arb_req_i,
    input  logic        alu2arb_add_sel_i,
    input  logic        alu2arb_mul_sel_i,
    input  logic [15:0] alu2arb_add_opd0_i,
    input  logic [15:0] alu2arb_add_opd1_i,
    input  logic [15:0] alu2arb_mul_opd0_i,
    input  logic [15:0] alu2arb_mul_opd1_i,
    output logic        arb2alu_ack_o,
    output logic [31:0] arb2alu_add_res_o,
    output logic [31:0] arb2alu_mul_res_o,
    input  logic        agu2arb_req_i,
    input  logic        agu2arb_add_sel_i,
    input  logic        agu2arb_mul_sel_i,
    input  logic [15:0] agu2arb_add_opd0_i,
    input  logic [15:0] agu2arb_add_opd1_i,
    input  logic [15:0] agu2arb_mul_opd0_i,
    input  logic [15:0] agu2arb_mul_opd1_i,
    output logic        arb2agu_ack_o,
    output logic [31:0] arb2agu_add_res_o,
    output logic [31:0] arb2agu_mul_res_o,
    output logic        arb2dsp_add_sel_o,
    output logic        arb2dsp_mul_sel_o,
    output logic [15:0] arb2dsp_add_opd0_o,
    output logic [15:0] arb2dsp_add_opd1_o,
    output logic [15:0] arb2dsp_mul_opd0_o,
    output logic [15:0] arb2dsp_mul_opd1_o,
    input  logic [31:0] dsp2arb_add_res_i,
    input  logic [31:0] dsp2arb_mul_res_i,
    output logic        arb_busy_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic        add_sel;
        logic        mul_sel;
        logic [15:0] add_opd0;
        logic [15:0] add_opd1;
        logic [15:0] mul_opd0;
        logic [15:0] mul_opd1;
    } dsp_op_t;

    localparam logic [1:0] LAT_LOAD = 2'(DSP_LAT);

    state_t      state_r, state_s;
    logic [1:0]  cnt_r, cnt_s;
    logic        win_agu_r, win_agu_s;
    logic        busy_r;
    dsp_op_t     dsp_r, dsp_s;
    dsp_op_t     alu_op_s, agu_op_s;
    logic        any_req_s, grant_agu_s;
    logic        alu_ack_r, alu_ack_s, agu_ack_r, agu_ack_s;
    logic [31:0] alu_add_res_r, alu_add_res_s, alu_mul_res_r, alu_mul_res_s;
    logic [31:0] agu_add_res_r, agu_add_res_s, agu_mul_res_r, agu_mul_res_s;
`ifdef N1_DSP_ARB_ROUNDROBIN_EN
    logic        last_agu_r, last_agu_s;
`endif

    assign alu_op_s = '{alu2arb_add_sel_i, alu2arb_mul_sel_i, alu2arb_add_opd0_i,
                        alu2arb_add_opd1_i, alu2arb_mul_opd0_i, alu2arb_mul_opd1_i};
    assign agu_op_s = '{agu2arb_add_sel_i, agu2arb_mul_sel_i, agu2arb_add_opd0_i,
                        agu2arb_add_opd1_i, agu2arb_mul_opd0_i, agu2arb_mul_opd1_i};

    // Pick the requester that would win if a grant happened this cycle.
    always_comb begin
        any_req_s   = alu2arb_req_i | agu2arb_req_i;
        grant_agu_s = 1'b0;
`ifdef N1_DSP_ARB_ROUNDROBIN_EN
        if (alu2arb_req_i && agu2arb_req_i) begin
            grant_agu_s = ~last_agu_r;
        end else begin
            grant_agu_s = agu2arb_req_i;
        end
`else
        if (alu2arb_req_i) begin
            grant_agu_s = 1'b0;
        end else begin
            grant_agu_s = agu2arb_req_i;
        end
`endif
    end

    // Next-state, operand latching and result capture.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        win_agu_s     = win_agu_r;
        dsp_s         = dsp_r;
        alu_ack_s     = 1'b0;
        agu_ack_s     = 1'b0;
        alu_add_res_s = alu_add_res_r;
        alu_mul_res_s = alu_mul_res_r;
        agu_add_res_s = agu_add_res_r;
        agu_mul_res_s = agu_mul_res_r;
`ifdef N1_DSP_ARB_ROUNDROBIN_EN
        last_agu_s    = last_agu_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_s   = ST_BUSY;
                    cnt_s     = LAT_LOAD;
                    win_agu_s = grant_agu_s;
                    if (grant_agu_s) begin
                        dsp_s = agu_op_s;
                    end else begin
                        dsp_s = alu_op_s;
                    end
`ifdef N1_DSP_ARB_ROUNDROBIN_EN
                    last_agu_s = grant_agu_s;
`endif
                end else begin
                    dsp_s = '0;
                end
            end
            ST_BUSY: begin
                // Operands stay frozen until the capture edge, then return to zero.
                if (cnt_r == 2'd1) begin
                    state_s = ST_IDLE;
                    cnt_s   = 2'd0;
                    dsp_s   = '0;
                    if (win_agu_r) begin
                        agu_add_res_s = dsp2arb_add_res_i;
                        agu_mul_res_s = dsp2arb_mul_res_i;
                        agu_ack_s     = 1'b1;
                    end else begin
                        alu_add_res_s = dsp2arb_add_res_i;
                        alu_mul_res_s = dsp2arb_mul_res_i;
                        alu_ack_s     = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r - 2'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 2'd0;
                dsp_s   = '0;
            end
        endcase
    end

    // State, operand and result registers.
    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 2'd0;
            win_agu_r     <= 1'b0;
            busy_r        <= 1'b0;
            dsp_r         <= '0;
            alu_ack_r     <= 1'b0;
            agu_ack_r     <= 1'b0;
            alu_add_res_r <= 32'd0;
            alu_mul_res_r <= 32'd0;
            agu_add_res_r <= 32'd0;
            agu_mul_res_r <= 32'd0;
`ifdef N1_DSP_ARB_ROUNDROBIN_EN
            last_agu_r    <= 1'b1;
`endif
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            win_agu_r     <= win_agu_s;
            busy_r        <= (state_s == ST_BUSY);
            dsp_r         <= dsp_s;
            alu_ack_r     <= alu_ack_s;
            agu_ack_r     <= agu_ack_s;
            alu_add_res_r <= alu_add_res_s;
            alu_mul_res_r <= alu_mul_res_s;
            agu_add_res_r <= agu_add_res_s;
            agu_mul_res_r <= agu_mul_res_s;
`ifdef N1_DSP_ARB_ROUNDROBIN_EN
            last_agu_r    <= last_agu_s;
`endif
        end
    end

    assign arb2alu_ack_o      = alu_ack_r;
    assign arb2alu_add_res_o  = alu_add_res_r;
    assign arb2alu_mul_res_o  = alu_mul_res_r;
    assign arb2agu_ack_o      = agu_ack_r;
    assign arb2agu_add_res_o  = agu_add_res_r;
    assign arb2agu_mul_res_o  = agu_mul_res_r;
    assign arb2dsp_add_sel_o  = dsp_r.add_sel;
    assign arb2dsp_mul_sel_o  = dsp_r.mul_sel;
    assign arb2dsp_add_opd0_o = dsp_r.add_opd0;
    assign arb2dsp_add_opd1_o = dsp_r.add_opd1;
    assign arb2dsp_mul_opd0_o = dsp_r.mul_opd0;
    assign arb2dsp_mul_opd1_o = dsp_r.mul_opd1;
    assign arb_busy_o         = busy_r;

endmodule

// File: tb/tb_n1_dsp_arb.sv
// Bench for n1_dsp_arb: directed scenarios plus random traffic against a transaction-level model.
// Honours N1_DSP_ARB_ROUNDROBIN_EN for the expected arbitration order.
module tb_n1_dsp_arb;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0]       req, add_sel, mul_sel;
    logic [1:0][15:0] a0, a1, m0, m1;
    logic [1:0]       ack;
    logic [1:0][31:0] add_res, mul_res;
    logic             d_add_sel, d_mul_sel, busy;
    logic [15:0]      d_a0, d_a1, d_m0, d_m1;
    logic [31:0]      dsp_add, dsp_mul;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    n1_dsp_arb #(.DSP_LAT(LAT)) u_dut (
        .clk_i(clk), .async_rst_i(rst_n),
        .alu2arb_req_i(req[0]), .alu2arb_add_sel_i(add_sel[0]), .alu2arb_mul_sel_i(mul_sel[0]),
        .alu2arb_add_opd0_i(a0[0]), .alu2arb_add_opd1_i(a1[0]),
        .alu2arb_mul_opd0_i(m0[0]), .alu2arb_mul_opd1_i(m1[0]),
        .arb2alu_ack_o(ack[0]), .arb2alu_add_res_o(add_res[0]), .arb2alu_mul_res_o(mul_res[0]),
        .agu2arb_req_i(req[1]), .agu2arb_add_sel_i(add_sel[1]), .agu2arb_mul_sel_i(mul_sel[1]),
        .agu2arb_add_opd0_i(a0[1]), .agu2arb_add_opd1_i(a1[1]),
        .agu2arb_mul_opd0_i(m0[1]), .agu2arb_mul_opd1_i(m1[1]),
        .arb2agu_ack_o(ack[1]), .arb2agu_add_res_o(add_res[1]), .arb2agu_mul_res_o(mul_res[1]),
        .arb2dsp_add_sel_o(d_add_sel), .arb2dsp_mul_sel_o(d_mul_sel),
        .arb2dsp_add_opd0_o(d_a0), .arb2dsp_add_opd1_o(d_a1),
        .arb2dsp_mul_opd0_o(d_m0), .arb2dsp_mul_opd1_o(d_m1),
        .dsp2arb_add_res_i(dsp_add), .dsp2arb_mul_res_i(dsp_mul),
        .arb_busy_o(busy)
    );

    // DSP cell: op bundle {add_sel, mul_sel, a0, a1, m0, m1} -> {add result, mul result}
    function automatic logic [63:0] dsp_fn(input logic [65:0] o);
        logic [31:0] ar, x0, x1, mr;
        if (o[65]) ar = {16'h0, o[63:48]} - {16'h0, o[47:32]};
        else       ar = {16'h0, o[63:48]} + {16'h0, o[47:32]};
        if (o[64]) begin
            x0 = {{16{o[31]}}, o[31:16]};
            x1 = {{16{o[15]}}, o[15:0]};
        end else begin
            x0 = {16'h0, o[31:16]};
            x1 = {16'h0, o[15:0]};
        end
        mr = x0 * x1;
        return {ar, mr};
    endfunction

    // DSP cell with LAT cycles from stable operands to valid results.
    logic [65:0] ops_now, dsp_ops;
    logic [65:0] pipe_q [1:2];
    assign ops_now = {d_add_sel, d_mul_sel, d_a0, d_a1, d_m0, d_m1};
    always @(posedge clk) begin
        pipe_q[1] <= ops_now;
        pipe_q[2] <= pipe_q[1];
    end
    assign dsp_ops = (LAT == 1) ? ops_now : (LAT == 2) ? pipe_q[1] : pipe_q[2];
    assign {dsp_add, dsp_mul} = dsp_fn(dsp_ops);

    // Transaction-level reference model
    int               cyc;
    bit               m_busy;
    int               m_done, m_win;
    bit               m_last_agu;
    logic [65:0]      m_ops, e_dsp;
    logic [1:0]       e_ack;
    logic [1:0][31:0] e_add, e_mul;

    function automatic logic [65:0] port_ops(input int p);
        return {add_sel[p], mul_sel[p], a0[p], a1[p], m0[p], m1[p]};
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_done = 0; m_win = 0; m_last_agu = 1'b1;
        m_ops = '0; e_dsp = '0; e_ack = '0; e_add = '0; e_mul = '0;
    endtask

    task automatic model_edge();
        e_ack = '0;
        if (!rst_n) begin
            model_reset();
        end else if (m_busy && cyc == m_done) begin
            {e_add[m_win], e_mul[m_win]} = dsp_fn(m_ops);
            e_ack[m_win] = 1'b1;
            m_busy = 1'b0;
            e_dsp  = '0;
        end else if (!m_busy && req != 2'b00) begin
            if (req == 2'b11) begin
`ifdef N1_DSP_ARB_ROUNDROBIN_EN
                m_win = m_last_agu ? 0 : 1;
`else
                m_win = 0;
`endif
            end else begin
                m_win = req[1] ? 1 : 0;
            end
            m_last_agu = (m_win == 1);
            m_ops  = port_ops(m_win);
            e_dsp  = m_ops;
            m_busy = 1'b1;
            m_done = cyc + LAT;
        end
    endtask

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("alu_ack", 66'(ack[0]), 66'(e_ack[0]));
        chk("agu_ack", 66'(ack[1]), 66'(e_ack[1]));
        chk("busy", 66'(busy), 66'(m_busy));
        chk("dsp_opds", ops_now, e_dsp);
        chk("alu_add_res", 66'(add_res[0]), 66'(e_add[0]));
        chk("alu_mul_res", 66'(mul_res[0]), 66'(e_mul[0]));
        chk("agu_add_res", 66'(add_res[1]), 66'(e_add[1]));
        chk("agu_mul_res", 66'(mul_res[1]), 66'(e_mul[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic set_ops(input int p, input logic as, input logic ms, input logic [15:0] x0,
                           input logic [15:0] x1, input logic [15:0] y0, input logic [15:0] y1);
        add_sel[p] = as; mul_sel[p] = ms; a0[p] = x0; a1[p] = x1; m0[p] = y0; m1[p] = y1;
    endtask

    int alu_t, agu_t;
    int order_q[$];
    int ack_ticks[$];

    initial begin
        rst_n = 1'b0;
        req = '0; add_sel = '0; mul_sel = '0; a0 = '0; a1 = '0; m0 = '0; m1 = '0;
        cyc = 0;
        model_reset();
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();

        // Simultaneous requests: ALU first, AGU one op later, AGU umul 0x00FF*0x0100
        set_ops(0, 1'b0, 1'b0, 16'h0002, 16'h0003, 16'h0003, 16'h0004);
        set_ops(1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h00FF, 16'h0100);
        req = 2'b11;
        alu_t = -1; agu_t = -1;
        for (int t = 1; t <= 2 * LAT + 4; t++) begin
            tick();
            if (ack[0] && alu_t < 0) alu_t = t;
            if (ack[1] && agu_t < 0) agu_t = t;
            if (e_ack[0]) req[0] = 1'b0;
            if (e_ack[1]) req[1] = 1'b0;
        end
        chk("t2_alu_ack_time", 66'(alu_t), 66'(LAT + 1));
        chk("t2_agu_ack_time", 66'(agu_t), 66'(2 * LAT + 2));
        chk("t2_agu_mul", 66'(mul_res[1]), 66'(32'h0000FF00));
        chk("t2_alu_add_kept", 66'(add_res[0]), 66'(32'h00000005));
        chk("t2_alu_mul_kept", 66'(mul_res[0]), 66'(32'h0000000C));

        // Both requests held continuously: grant order
        req = 2'b11;
        order_q.delete();
        for (int t = 1; t <= 4 * (LAT + 1); t++) begin
            tick();
            if (ack[0]) order_q.push_back(0);
            if (ack[1]) order_q.push_back(1);
        end
        req = 2'b00;
        chk("t3_grant_count", 66'(order_q.size()), 66'(4));
        for (int i = 0; i < 4; i++) begin
`ifdef N1_DSP_ARB_ROUNDROBIN_EN
            chk("t3_grant_order", 66'((i < order_q.size()) ? order_q[i] : 9), 66'(i % 2));
`else
            chk("t3_grant_order", 66'((i < order_q.size()) ? order_q[i] : 9), 66'(0));
`endif
        end
        repeat (LAT + 2) tick();

        // ALU add 0x1234 + 0x0001
        set_ops(0, 1'b0, 1'b0, 16'h1234, 16'h0001, 16'h0000, 16'h0000);
        req[0] = 1'b1;
        tick();
        chk("t1_opd0", 66'(d_a0), 66'(16'h1234));
        chk("t1_opd1", 66'(d_a1), 66'(16'h0001));
        repeat (LAT) tick();
        chk("t1_ack", 66'(ack[0]), 66'(1'b1));
        chk("t1_add_res", 66'(add_res[0]), 66'(32'h00001235));
        req[0] = 1'b0;
        tick();
        chk("t1_ack_pulse", 66'(ack[0]), 66'(1'b0));

        // ALU request held through acks: one op every LAT+1 cycles
        set_ops(0, 1'b1, 1'b1, 16'h0010, 16'h0020, 16'hFFFE, 16'h0003);
        req[0] = 1'b1;
        ack_ticks.delete();
        for (int t = 1; t <= 3 * (LAT + 1); t++) begin
            tick();
            if (ack[0]) ack_ticks.push_back(t);
        end
        req[0] = 1'b0;
        chk("t4_ack_count", 66'(ack_ticks.size()), 66'(3));
        for (int i = 0; i < 3; i++) begin
            chk("t4_ack_time", 66'((i < ack_ticks.size()) ? ack_ticks[i] : -1), 66'((i + 1) * (LAT + 1)));
        end
        chk("t4_smul", 66'(mul_res[0]), 66'(32'hFFFFFFFA));
        chk("t4_sub", 66'(add_res[0]), 66'(32'hFFFFFFF0));

        // Random traffic: requesters hold req until acked, may go back-to-back
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) begin
                set_ops(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                        16'($urandom), 16'($urandom), 16'($urandom));
            end
            tick();
            for (int p = 0; p < 2; p++) begin
                if (req[p] && e_ack[p]) req[p] = 1'($urandom_range(0, 1));
                else if (!req[p]) req[p] = ($urandom_range(0, 2) == 0);
            end
        end

        // Quiet period: operands zero, not busy, results held
        req = 2'b00;
        repeat (LAT + 10) tick();
        chk("t6_busy", 66'(busy), 66'(1'b0));
        chk("t6_opds", ops_now, 66'(0));

        // Reset asserted in the second BUSY cycle
        set_ops(0, 1'b0, 1'b1, 16'h4444, 16'h1111, 16'h0102, 16'h0304);
        req[0] = 1'b1;
        tick();
        tick();
        #3 rst_n = 1'b0;
        req = 2'b00;
        #1;
        model_reset();
        compare_all();
        chk("t5_opds_zero", ops_now, 66'(0));
        tick();
        #2 rst_n = 1'b1;
        alu_t = 0;
        for (int t = 0; t < LAT + 3; t++) begin
            tick();
            if (ack[0] || ack[1]) alu_t++;
        end
        chk("t5_no_ack", 66'(alu_t), 66'(0));
        chk("t5_idle", 66'(busy), 66'(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
